// File: rtl/chunked_add_sub_pkg.sv
// rtl/chunked_add_sub_pkg.sv - shared state encoding and sizing helper for chunked_add_sub
package chunked_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Chunk index counter needs at least one bit even when there is a single chunk.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit ripple adder for one slice
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[CHUNK];
    end

endmodule

// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle add/sub, one CHUNK-bit slice per clock, LSB first
module chunked_add_sub
    import chunked_add_sub_pkg::*;
#(
    parameter int PROC_SIZE = 16,
    parameter int CHUNK     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PROC_SIZE-1:0] a_i,
    input  logic [PROC_SIZE-1:0] b_i,
    input  logic                 sub_i,
    input  logic                 cin_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PROC_SIZE-1:0] sum_o,
    output logic                 cout_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int NCHUNK = PROC_SIZE / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam int MSB    = PROC_SIZE - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > PROC_SIZE || (PROC_SIZE % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_add_sub: CHUNK must divide PROC_SIZE and lie in 1..PROC_SIZE");
    end

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [PROC_SIZE-1:0] a_q;
    logic [PROC_SIZE-1:0] b_q;
    logic                 carry_q;
    logic [PROC_SIZE-1:0] sum_q;
    logic                 cout_q;
    logic                 overflow_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;

    assign idx_d   = idx_q + 1'b1;
    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (s_chunk),
        .cout_o (c_chunk)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        // Subtraction is A + ~B + 1, so B is inverted and carry seeded here.
                        a_q        <= a_i;
                        b_q        <= b_i ^ {PROC_SIZE{sub_i}};
                        carry_q    <= sub_i ? 1'b1 : cin_i;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= s_chunk;
                    carry_q <= c_chunk;
                    idx_q   <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        cout_q      <= c_chunk;
                        overflow_q  <= (a_q[MSB] == b_q[MSB]) && (s_chunk[CHUNK-1] != a_q[MSB]);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - scoreboard bench for chunked_add_sub
module tb_chunked_add_sub;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;
    logic          busy;

    logic [1:0]    xiv = '0;
    logic [1:0]    xir;
    logic [1:0]    xov;
    logic [1:0]    xcout;
    logic [1:0]    xovf;
    logic [1:0]    xbusy;
    logic [1:0]    xsub = '0;
    logic [1:0]    xcin = '0;
    logic [W-1:0]  xa [2];
    logic [W-1:0]  xb [2];
    logic [W-1:0]  xsum [2];

    always #5 clk = ~clk;

    chunked_add_sub #(.PROC_SIZE(W), .CHUNK(CH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .cin_i       (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .overflow_o  (overflow),
        .busy_o      (busy)
    );

    for (genvar g = 0; g < 2; g++) begin : g_x
        chunked_add_sub #(.PROC_SIZE(W), .CHUNK(g == 0 ? 1 : 16)) u_x (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (xiv[g]),
            .in_ready_o  (xir[g]),
            .a_i         (xa[g]),
            .b_i         (xb[g]),
            .sub_i       (xsub[g]),
            .cin_i       (xcin[g]),
            .out_valid_o (xov[g]),
            .out_ready_i (1'b1),
            .sum_o       (xsum[g]),
            .cout_o      (xcout[g]),
            .overflow_o  (xovf[g]),
            .busy_o      (xbusy[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    bit   first = 1'b1;
    bit   hold  = 1'b0;

    // Reference: plain integer arithmetic, signed range test for overflow, a>=b for no-borrow.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms, input logic mc);
        int sa = int'($signed(ma));
        int sb = int'($signed(mb));
        int ua = int'(ma);
        int ub = int'(mb);
        int res;
        int ures;
        logic co;
        if (ms) begin
            res  = sa - sb;
            ures = ua - ub;
            co   = (ua >= ub);
        end else begin
            res  = sa + sb + int'(mc);
            ures = ua + ub + int'(mc);
            co   = (ures >= 65536);
        end
        return {co, (res > 32767 || res < -32768), ures[W-1:0]};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 9) < 7);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sbq[0];
                if (first) begin
                    chk("latency", cyc - e.acc, NCH);
                    first = 1'b0;
                end
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("busy_done", 32'(busy), 32'd1);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.sum = es; e.cout = ec; e.ov = eo; e.acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || !in_ready) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic run_x(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, input logic tc, input logic [W-1:0] es,
                         input logic ec, input logic eo);
        int n = 0;
        int acc;
        @(negedge clk);
        xa[k] = ta; xb[k] = tb; xsub[k] = ts; xcin[k] = tc; xiv[k] = 1'b1;
        while (!xir[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!xir[k]) begin
            chk("x_accept_timeout", 32'd0, 32'd1);
            xiv[k] = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        xiv[k] = 1'b0;
        n = 0;
        while (!xov[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("x_out_valid", 32'(xov[k]), 32'd1);
        chk("x_latency", cyc - acc, (k == 0) ? 16 : 1);
        chk("x_sum", 32'(xsum[k]), 32'(es));
        chk("x_cout", 32'(xcout[k]), 32'(ec));
        chk("x_overflow", 32'(xovf[k]), 32'(eo));
    endtask

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         c;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t dir [6] = '{
        '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0},
        '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1}
    };

    initial begin
        logic [W+1:0] r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rc;
        int           n;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("in_ready_after_edge", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++)
            issue(dir[i].a, dir[i].b, dir[i].s, dir[i].c, dir[i].es, dir[i].ec, dir[i].eo);
        drain();

        // Stall the consumer: result must hold and new requests must be refused.
        hold = 1'b1;
        r = model(16'hABCD, 16'h1111, 1'b0, 1'b1);
        issue(16'hABCD, 16'h1111, 1'b0, 1'b1, r[W-1:0], r[W+1], r[W]);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        hold = 1'b0;
        drain();

        // Abort an operation mid-RUN with an asynchronous reset.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        sbq.delete();
        first = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_release_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("abort_next_in_ready", 32'(in_ready), 32'd1);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) rb = ~ra;
            r = model(ra, rb, rs, rc);
            issue(ra, rb, rs, rc, r[W-1:0], r[W+1], r[W]);
        end
        drain();

        for (int k = 0; k < 2; k++)
            for (int i = 1; i < 4; i++)
                run_x(k, dir[i].a, dir[i].b, dir[i].s, dir[i].c, dir[i].es, dir[i].ec, dir[i].eo);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
